sseg_scan_driver: RTL

//  Downstream display stage for the 3-bit add/sub ALU. Accepts the sum (0..15)
//  and signed difference (-8..7) through a valid/ready handshake and drives the
//  4-digit common-anode seven-segment display.

---
 rtl/sseg_scan_driver_if.sv | 27 ++
 rtl/sseg_scan_driver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_driver_if
// Brief    : Result handshake between the ALU and the seven-segment driver.
// Revision : 1.0 - initial release
// ============================================================================
interface sseg_scan_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] sum_in;
  logic [3:0] diff_in;

  modport master (
    output in_valid,
    output sum_in,
    output diff_in,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  sum_in,
    input  diff_in,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_driver
// Brief    : 4-digit common-anode scan driver showing ALU sum and difference.
// Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  wire                   clk,
  input  wire                   reset,
  sseg_scan_driver_if.slave     bus,
  output logic [6:0]            seg,
  output logic [3:0]            an,
  output logic                  frame_tick
);

  localparam int              CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] C_TC = CNT_W'(REFRESH_DIV - 1);

  localparam logic [1:0] S_DIG0 = 2'd0;
  localparam logic [1:0] S_DIG1 = 2'd1;
  localparam logic [1:0] S_DIG2 = 2'd2;
  localparam logic [1:0] S_DIG3 = 2'd3;

  localparam logic [6:0] C_BLANK = 7'b1111111;
  localparam logic [6:0] C_MINUS = 7'b0111111;

  logic [CNT_W-1:0] r_presc;
  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic             w_tc;
  logic             w_boundary;

  logic             r_pending;
  logic [3:0]       r_pend_sum;
  logic [3:0]       r_pend_diff;
  logic [3:0]       r_shown_sum;
  logic [3:0]       r_shown_diff;
  logic             w_capture;

  logic             w_tens;
  logic [3:0]       w_ones;
  logic             w_neg;
  logic [3:0]       w_mag;
  logic [6:0]       w_seg_next;
  logic [3:0]       w_an_next;

  logic [6:0]       r_seg;
  logic [3:0]       r_an;
  logic             r_frame_tick;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = C_BLANK;
    endcase
    return g;
  endfunction

  assign w_tc       = (r_presc == C_TC);
  assign w_boundary = w_tc && (r_state == S_DIG3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tc) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Digit scan state: register, next-state, output decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_DIG0;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_tc) begin
      case (r_state)
        S_DIG0:  w_state_next = S_DIG1;
        S_DIG1:  w_state_next = S_DIG2;
        S_DIG2:  w_state_next = S_DIG3;
        S_DIG3:  w_state_next = S_DIG0;
        default: w_state_next = S_DIG0;
      endcase
    end
  end

  assign w_tens = (r_shown_sum >= 4'd10);
  assign w_ones = w_tens ? (r_shown_sum - 4'd10) : r_shown_sum;
  assign w_neg  = r_shown_diff[3];
  // Negating -8 wraps back to 4'b1000, which reads correctly as unsigned 8.
  assign w_mag  = w_neg ? (~r_shown_diff + 4'd1) : r_shown_diff;

  always_comb begin
    w_seg_next = C_BLANK;
    w_an_next  = 4'b1111;
    case (r_state)
      S_DIG0: begin
        w_an_next  = 4'b1110;
        w_seg_next = glyph(w_mag);
      end
      S_DIG1: begin
        w_an_next  = 4'b1101;
        w_seg_next = w_neg ? C_MINUS : C_BLANK;
      end
      S_DIG2: begin
        w_an_next  = 4'b1011;
        w_seg_next = glyph(w_ones);
      end
      S_DIG3: begin
        w_an_next  = 4'b0111;
        w_seg_next = w_tens ? glyph(4'd1) : C_BLANK;
      end
      default: begin
        w_an_next  = 4'b1111;
        w_seg_next = C_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg        <= C_BLANK;
      r_an         <= 4'b1111;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= w_seg_next;
      r_an         <= w_an_next;
      r_frame_tick <= w_boundary;
    end
  end

  assign bus.in_ready = ~r_pending;
  assign w_capture    = bus.in_valid && ~r_pending;

  // A capture on the boundary cycle only happens with pending clear, so the
  // shown copy is untouched and the new value waits for the next boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending    <= 1'b0;
      r_pend_sum   <= 4'd0;
      r_pend_diff  <= 4'd0;
      r_shown_sum  <= 4'd0;
      r_shown_diff <= 4'd0;
    end else if (w_capture) begin
      r_pending    <= 1'b1;
      r_pend_sum   <= bus.sum_in;
      r_pend_diff  <= bus.diff_in;
    end else if (w_boundary && r_pending) begin
      r_pending    <= 1'b0;
      r_shown_sum  <= r_pend_sum;
      r_shown_diff <= r_pend_diff;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire
